// File: rtl/regfile_wb_scheduler.sv
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Shares the register file's single write port between the ALU
//               and LSU writeback sources using round-robin arbitration. It
//               also keeps a busy scoreboard of pending destination registers
//               and holds off decode issue on RAW/WAW hazards.
//
// Build macro : WB_BYPASS_EN
//               When defined, the in-flight write (DataD) is forwarded to the
//               decode operands, and the busy bits clear on the grant edge.
//               When undefined, the operands pass straight through, and the
//               busy bits clear when the register file commits.
//
// Ports       :
//   Clk, Rst_n                   clock; asynchronous active-low reset
//   Alu_Valid/Ready/Rd/Data      ALU writeback handshake
//   Lsu_Valid/Ready/Rd/Data      LSU writeback handshake
//   Issue_Valid/Ready            decode issue handshake (Ready = no hazard)
//   Issue_Rd/RsA/RsB             destination and source registers
//   AddrD, DataD, RegWEn         registered register file write port
//   Busy                         scoreboard vector, bit i = reg i pending
//   RfDataA, RfDataB             register file read data
//   FwdDataA, FwdDataB           operands delivered to decode
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Alu_Valid,
  output logic                  Alu_Ready,
  input  logic [AW-1:0]         Alu_Rd,
  input  logic [XLEN-1:0]       Alu_Data,
  input  logic                  Lsu_Valid,
  output logic                  Lsu_Ready,
  input  logic [AW-1:0]         Lsu_Rd,
  input  logic [XLEN-1:0]       Lsu_Data,
  input  logic                  Issue_Valid,
  output logic                  Issue_Ready,
  input  logic [AW-1:0]         Issue_Rd,
  input  logic [AW-1:0]         Issue_RsA,
  input  logic [AW-1:0]         Issue_RsB,
  output logic [AW-1:0]         AddrD,
  output logic [XLEN-1:0]       DataD,
  output logic                  RegWEn,
  output logic [(1<<AW)-1:0]    Busy,
  input  logic [XLEN-1:0]       RfDataA,
  input  logic [XLEN-1:0]       RfDataB,
  output logic [XLEN-1:0]       FwdDataA,
  output logic [XLEN-1:0]       FwdDataB
);

  localparam int NREG = 1 << AW;

  // Round-robin pointer: 1 means the LSU was granted last, so the ALU wins
  // the next tie. Reset value gives the ALU the first tie.
  logic                 r_last_lsu;
  logic [AW-1:0]        r_addr;
  logic [XLEN-1:0]      r_data;
  logic                 r_regwen;
  logic [NREG-1:0]      r_busy;

  logic                 w_gnt_alu;
  logic                 w_gnt_lsu;
  logic                 w_gnt;
  logic [AW-1:0]        w_gnt_rd;
  logic [XLEN-1:0]      w_gnt_data;
  logic                 w_hazard;
  logic                 w_issue_fire;
  logic [NREG-1:0]      w_set_vec;
  logic [NREG-1:0]      w_clr_vec;
  logic [NREG-1:0]      w_busy_nxt;

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    w_gnt_alu  = Alu_Valid && (!Lsu_Valid || r_last_lsu);
    w_gnt_lsu  = Lsu_Valid && !w_gnt_alu;
    w_gnt      = w_gnt_alu || w_gnt_lsu;
    w_gnt_rd   = '0;
    w_gnt_data = '0;
    if (w_gnt_alu) begin
      w_gnt_rd   = Alu_Rd;
      w_gnt_data = Alu_Data;
    end else if (w_gnt_lsu) begin
      w_gnt_rd   = Lsu_Rd;
      w_gnt_data = Lsu_Data;
    end
  end

  assign Alu_Ready = w_gnt_alu;
  assign Lsu_Ready = w_gnt_lsu;

  // ------------------------------------------------------- write port stage
  // A grant to x0 still loads AddrD/DataD but never raises RegWEn.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_last_lsu <= 1'b1;
      r_addr     <= '0;
      r_data     <= '0;
      r_regwen   <= 1'b0;
    end else begin
      r_regwen <= 1'b0;
      if (w_gnt) begin
        r_last_lsu <= w_gnt_lsu;
        r_addr     <= w_gnt_rd;
        r_data     <= w_gnt_data;
        r_regwen   <= (w_gnt_rd != '0);
      end
    end
  end

  assign AddrD  = r_addr;
  assign DataD  = r_data;
  assign RegWEn = r_regwen;

  // ------------------------------------------------------------- scoreboard
  always_comb begin
    w_hazard     = r_busy[Issue_RsA] | r_busy[Issue_RsB] | r_busy[Issue_Rd];
    w_issue_fire = Issue_Valid && !w_hazard && (Issue_Rd != '0);

    w_set_vec = '0;
    if (w_issue_fire) begin
      w_set_vec[Issue_Rd] = 1'b1;
    end

    w_clr_vec = '0;
`ifdef WB_BYPASS_EN
    // Clear as the write is granted; the dependant reads DataD via bypass.
    if (w_gnt) begin
      w_clr_vec[w_gnt_rd] = 1'b1;
    end
`else
    // Clear at the end of the RegWEn cycle, when the register file commits.
    if (r_regwen) begin
      w_clr_vec[r_addr] = 1'b1;
    end
`endif

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    w_busy_nxt    = (r_busy & ~w_clr_vec) | w_set_vec;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign Busy        = r_busy;
  assign Issue_Ready = !w_hazard;

  // ------------------------------------------------------------ operand mux
`ifdef WB_BYPASS_EN
  assign FwdDataA = (r_regwen && (r_addr == Issue_RsA) && (Issue_RsA != '0)) ? r_data : RfDataA;
  assign FwdDataB = (r_regwen && (r_addr == Issue_RsB) && (Issue_RsB != '0)) ? r_data : RfDataB;
`else
  assign FwdDataA = RfDataA;
  assign FwdDataB = RfDataB;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Self-checking bench for regfile_wb_scheduler. A behavioural
//               model predicts grants, hazards, operands and the busy vector,
//               and queues the expected write-port values, which a separate
//               monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_scheduler;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Alu_Valid = 1'b0, Lsu_Valid = 1'b0, Issue_Valid = 1'b0;
  logic              Alu_Ready, Lsu_Ready, Issue_Ready, RegWEn;
  logic [AW-1:0]     Alu_Rd = '0, Lsu_Rd = '0, Issue_Rd = '0, Issue_RsA = '0, Issue_RsB = '0;
  logic [XLEN-1:0]   Alu_Data = '0, Lsu_Data = '0, RfDataA = '0, RfDataB = '0;
  logic [AW-1:0]     AddrD;
  logic [XLEN-1:0]   DataD, FwdDataA, FwdDataB;
  logic [NREG-1:0]   Busy;

  regfile_wb_scheduler #(.XLEN(XLEN), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Rd(Alu_Rd), .Alu_Data(Alu_Data),
    .Lsu_Valid(Lsu_Valid), .Lsu_Ready(Lsu_Ready), .Lsu_Rd(Lsu_Rd), .Lsu_Data(Lsu_Data),
    .Issue_Valid(Issue_Valid), .Issue_Ready(Issue_Ready), .Issue_Rd(Issue_Rd),
    .Issue_RsA(Issue_RsA), .Issue_RsB(Issue_RsB),
    .AddrD(AddrD), .DataD(DataD), .RegWEn(RegWEn), .Busy(Busy),
    .RfDataA(RfDataA), .RfDataB(RfDataB), .FwdDataA(FwdDataA), .FwdDataB(FwdDataB)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------ model state
  typedef struct {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    bit              we;
    int              due;
  } wr_t;

  wr_t             exp_q[$];
  bit              last_lsu;          // LSU took the previous grant
  bit              busy_m [NREG];
  bit              wr_v_m;            // a real write is on the port this cycle
  logic [AW-1:0]   wr_a_m;
`ifdef WB_BYPASS_EN
  logic [XLEN-1:0] wr_d_m;
`endif

  task automatic model_reset();
    last_lsu = 1'b1;
    for (int i = 0; i < NREG; i++) busy_m[i] = 1'b0;
    wr_v_m = 1'b0;
    wr_a_m = '0;
`ifdef WB_BYPASS_EN
    wr_d_m = '0;
`endif
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- monitor
  bit              mon_en = 1'b0;
  logic [AW-1:0]   last_a = '0;
  logic [XLEN-1:0] last_d = '0;
  wr_t             mon_e;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        chk("regwen", RegWEn, mon_e.we);
        chk("addrd", AddrD, mon_e.a);
        chk("datad", DataD, mon_e.d);
        last_a = mon_e.a;
        last_d = mon_e.d;
      end else begin
        chk("regwen_idle", RegWEn, 1'b0);
        chk("addrd_hold", AddrD, last_a);
        chk("datad_hold", DataD, last_d);
      end
    end
  end

  // ----------------------------------------------------------------- driver
  // Applies one cycle of stimulus, checks the combinational outputs against
  // the model mid-cycle, then advances the model across the next edge.
  task automatic cycle_go(
    input bit av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
    input bit lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldat,
    input bit iv, input logic [AW-1:0] ird, input logic [AW-1:0] irsa,
    input logic [AW-1:0] irsb);
    bit              ga, gl, haz;
    logic [AW-1:0]   g_rd;
    logic [XLEN-1:0] g_d, efa, efb;
    logic [NREG-1:0] bvec;
    Alu_Valid = av;  Alu_Rd = ard;  Alu_Data = adat;
    Lsu_Valid = lv;  Lsu_Rd = lrd;  Lsu_Data = ldat;
    Issue_Valid = iv; Issue_Rd = ird; Issue_RsA = irsa; Issue_RsB = irsb;
    RfDataA = $urandom; RfDataB = $urandom;
    @(negedge Clk);

    ga = av && (!lv || last_lsu);
    gl = lv && !ga;
    chk("alu_ready", Alu_Ready, ga);
    chk("lsu_ready", Lsu_Ready, gl);

    haz = busy_m[irsa] || busy_m[irsb] || busy_m[ird];
    chk("issue_ready", Issue_Ready, !haz);

    for (int i = 0; i < NREG; i++) bvec[i] = busy_m[i];
    chk("busy", Busy, bvec);

    efa = RfDataA;
    efb = RfDataB;
`ifdef WB_BYPASS_EN
    if (wr_v_m && wr_a_m == irsa && irsa != 0) efa = wr_d_m;
    if (wr_v_m && wr_a_m == irsb && irsb != 0) efb = wr_d_m;
`endif
    chk("fwd_a", FwdDataA, efa);
    chk("fwd_b", FwdDataB, efb);

    g_rd = ga ? ard : lrd;
    g_d  = ga ? adat : ldat;
`ifdef WB_BYPASS_EN
    if (ga || gl) busy_m[g_rd] = 1'b0;
`else
    if (wr_v_m) busy_m[wr_a_m] = 1'b0;
`endif
    if (iv && !haz && ird != 0) busy_m[ird] = 1'b1;
    busy_m[0] = 1'b0;

    if (ga || gl) begin
      last_lsu = gl;
      exp_q.push_back('{a: g_rd, d: g_d, we: (g_rd != 0), due: cyc + 1});
    end
    wr_v_m = (ga || gl) && (g_rd != 0);
    wr_a_m = g_rd;
`ifdef WB_BYPASS_EN
    wr_d_m = g_d;
`endif
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle_go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // -------------------------------------------------------------- sequence
  initial begin
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_addrd", AddrD, 0);
    chk("rst_datad", DataD, 0);
    chk("rst_regwen", RegWEn, 0);
    chk("rst_busy", Busy, 0);
    Rst_n = 1'b1;
    last_a = '0; last_d = '0;
    mon_en = 1'b1;

    // Both sources valid for four cycles: ALU and LSU alternate.
    for (int k = 0; k < 4; k++)
      cycle_go(1, 5'd1, $urandom, 1, 5'd2, $urandom, 0, 0, 0, 0);
    idle(1);

    // Single ALU writeback.
    cycle_go(1, 5'd5, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // LSU writeback to x0: acked, no write enable.
    cycle_go(0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0);
    idle(1);

    // RAW on x3: issue, then hold a dependant while the ALU writes x3.
    cycle_go(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd0, 5'd0);
    cycle_go(1, 5'd3, 32'h1234_5678, 0, 0, 0, 1, 5'd0, 5'd3, 5'd0);
    for (int k = 0; k < 3; k++) cycle_go(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd3, 5'd0);

    // Issue to x7 in the same cycle its clear point lands: set wins.
`ifdef WB_BYPASS_EN
    cycle_go(1, 5'd7, 32'h77, 0, 0, 0, 1, 5'd7, 5'd0, 5'd0);
`else
    cycle_go(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    cycle_go(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd0);
`endif
    idle(2);

    // Asynchronous reset in the middle of a burst.
    cycle_go(1, 5'd9, $urandom, 1, 5'd10, $urandom, 1, 5'd11, 5'd0, 5'd0);
    mon_en = 1'b0;
    Alu_Valid = 0; Lsu_Valid = 0; Issue_Valid = 0;
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_regwen", RegWEn, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_addrd", AddrD, 0);
    chk("arst_datad", DataD, 0);
    model_reset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    last_a = '0; last_d = '0;
    mon_en = 1'b1;

    // Randomized traffic over a small register window to provoke hazards.
    for (int k = 0; k < 1500; k++)
      cycle_go($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)),
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
